// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - multi-domain reset sequencer; optional sw reset request via RST_SEQ_SW_REQ_EN
//
// Qualifies an asynchronous PLL lock, then releases NUM_DOMAINS active-low
// domain resets one at a time, bit 0 first. Lock loss (or, when
// RST_SEQ_SW_REQ_EN is defined, a software request while running) pulls every
// domain back into reset, holds for STAGE_DELAY cycles, and restarts.

module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8,
  parameter int STAGE_DELAY = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   pll_locked_in,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   seq_done,
  output logic [2:0]             state_out,
  output logic [7:0]             lock_lost_cnt
);

  // Counter widths follow the terminal value each counter must reach.
  localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int STG_W  = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [FILT_W-1:0]      r_filt_cnt;
  // Shared between the RELEASE stage spacing and the FAULT hold; the two
  // states never overlap and both run to STAGE_DELAY-1.
  logic [STG_W-1:0]       r_stage_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic                   r_seq_done;
  logic [7:0]             r_lock_lost_cnt;

  logic                   w_lock;
  logic                   w_sw_req;
  logic                   w_fault_loss;
  logic                   w_fault_sw;
  logic [7:0]             w_lost_cnt_inc;
  logic [NUM_DOMAINS-1:0] w_rel_mask;

  assign w_lock = r_sync[SYNC_STAGES-1];

`ifdef RST_SEQ_SW_REQ_EN
  assign w_sw_req = sw_rst_req;
`else
  // Port kept for pin compatibility; the request has no effect in this build.
  logic w_unused_sw_req;
  assign w_unused_sw_req = sw_rst_req;
  assign w_sw_req        = 1'b0;
`endif

  // Lock loss wins over a simultaneous software request so it is counted.
  assign w_fault_loss = ((r_state == ST_RELEASE) || (r_state == ST_RUN)) && !w_lock;
  assign w_fault_sw   = (r_state == ST_RUN) && w_lock && w_sw_req;

  assign w_lost_cnt_inc = (r_lock_lost_cnt == 8'hFF) ? 8'hFF : (r_lock_lost_cnt + 8'd1);

  // One-hot mask selecting the domain released next.
  always_comb begin
    w_rel_mask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      w_rel_mask[i] = (r_idx == IDX_W'(i));
    end
  end

  // Lock synchronizer: bring the asynchronous PLL lock into clk_in.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked_in};
    end
  end

  // Sequencer FSM with registered domain resets, done flag and fault count.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state         <= ST_RESET;
      r_filt_cnt      <= '0;
      r_stage_cnt     <= '0;
      r_idx           <= '0;
      r_rst_n         <= '0;
      r_seq_done      <= 1'b0;
      r_lock_lost_cnt <= '0;
    end else if (w_fault_loss || w_fault_sw) begin
      r_state     <= ST_FAULT;
      r_stage_cnt <= '0;
      r_idx       <= '0;
      r_rst_n     <= '0;
      r_seq_done  <= 1'b0;
      if (w_fault_loss) begin
        r_lock_lost_cnt <= w_lost_cnt_inc;
      end
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state    <= ST_WAIT_LOCK;
          r_filt_cnt <= '0;
        end

        ST_WAIT_LOCK: begin
          if (!w_lock) begin
            r_filt_cnt <= '0;
          end else if (r_filt_cnt == FILT_LAST) begin
            r_state     <= ST_RELEASE;
            r_filt_cnt  <= '0;
            r_stage_cnt <= '0;
            r_idx       <= '0;
          end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (r_stage_cnt == STG_LAST) begin
            r_stage_cnt <= '0;
            r_rst_n     <= r_rst_n | w_rel_mask;
            if (r_idx == IDX_LAST) begin
              r_state    <= ST_RUN;
              r_seq_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_stage_cnt <= r_stage_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          r_rst_n    <= '1;
          r_seq_done <= 1'b1;
        end

        ST_FAULT: begin
          // Fixed hold: lock activity is deliberately ignored here.
          if (r_stage_cnt == STG_LAST) begin
            r_state     <= ST_WAIT_LOCK;
            r_stage_cnt <= '0;
            r_filt_cnt  <= '0;
          end else begin
            r_stage_cnt <= r_stage_cnt + 1'b1;
          end
        end

        default: begin
          r_state     <= ST_RESET;
          r_filt_cnt  <= '0;
          r_stage_cnt <= '0;
          r_idx       <= '0;
          r_rst_n     <= '0;
          r_seq_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rst_n_out     = r_rst_n;
  assign seq_done      = r_seq_done;
  assign state_out     = r_state;
  assign lock_lost_cnt = r_lock_lost_cnt;

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Multi-domain reset sequencer that sits downstream of the clock/reset generator. It takes the raw board reset and an asynchronous PLL-lock indication, qualifies and filters lock, then releases up to NUM_DOMAINS active-low domain resets one at a time in fixed order. On lock loss or software request it re-asserts all domain resets, holds them, and restarts the sequence. It also keeps a saturating lock-loss event count for diagnostics.

## Interface
- NUM_DOMAINS, 4: number of reset domains, legal 1..8
- SYNC_STAGES, 2: synchronizer depth for pll_locked_in, legal 2..4
- LOCK_FILTER, 8: consecutive synced-high lock cycles required before release, ≥1
- STAGE_DELAY, 16: cycles between successive domain releases; also the FAULT hold length, ≥1

- clk_in  input  1  sequencer clock
- reset_in  input  1  asynchronous, active-high reset
- pll_locked_in  input  1  PLL lock, asynchronous to clk_in
- sw_rst_req  input  1  single-cycle software reset request, synchronous to clk_in
- rst_n_out  output  NUM_DOMAINS  per-domain active-low reset, bit 0 released first
- seq_done  output  1  high while all domains are released (RUN)
- state_out  output  3  current FSM state encoding
- lock_lost_cnt  output  8  saturating count of lock-loss faults

## Operation
- pll_locked_in passes through a SYNC_STAGES flop chain; "lock" below means the synchronized value.
- FSM states and encodings: RESET=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4. Other codes are unreachable and recover to RESET.
- RESET: entered asynchronously on reset_in. Moves to WAIT_LOCK on the first clk_in edge after reset_in deasserts.
- WAIT_LOCK: filter counter increments while lock=1 and clears when lock=0. When the counter reaches LOCK_FILTER-1 with lock=1, the FSM moves to RELEASE with stage counter=0 and idx=0.
- RELEASE: the stage counter increments each cycle. When it equals STAGE_DELAY-1, rst_n_out[idx] is set to 1, the stage counter clears and idx increments. Releasing idx=NUM_DOMAINS-1 moves the FSM to RUN.
- RUN: seq_done=1. All rst_n_out stay high.
- FAULT entry:
  - from RELEASE or RUN when lock=0;
  - from RUN when sw_rst_req=1 (only if RST_SEQ_SW_REQ_EN is defined).
- On FAULT entry, all rst_n_out go to 0 and seq_done goes to 0 on the same clock edge.
- lock_lost_cnt increments on entry caused by lock loss only, saturating at 255. Entry caused by a software request does not increment it.
- Lock loss and sw_rst_req in the same cycle count as lock loss.
- FAULT: hold counter runs for STAGE_DELAY cycles, then the FSM moves to WAIT_LOCK with the filter counter cleared. Lock toggling during FAULT does not shorten or extend the hold.
- sw_rst_req outside RUN is ignored.
- Counters are sized with $clog2 of their terminal value, minimum 1 bit. No counter wraps.

## Timing
- Reset values:
  - rst_n_out = all 0
  - seq_done = 0
  - state_out = 0
  - lock_lost_cnt = 0
  - all internal counters and the synchronizer = 0
- All outputs are registered. There is no combinational path from input to output.
- Lock latency: a lock rising edge becomes visible after SYNC_STAGES cycles. RELEASE is entered LOCK_FILTER cycles after the first synced-high sample.
- Domain k deasserts exactly (k+1)·STAGE_DELAY cycles after the cycle in which state_out first reads RELEASE. RUN and seq_done follow on that same edge for k=NUM_DOMAINS-1.
- Lock-loss response: at most SYNC_STAGES+1 cycles from the pll_locked_in falling edge to all rst_n_out=0.
- reset_in asserted mid-sequence: all outputs return to reset values asynchronously, and lock_lost_cnt clears.

## Configuration
- RST_SEQ_SW_REQ_EN defined: sw_rst_req in RUN enters FAULT as described above.
- Not defined: sw_rst_req is ignored in all states; the port remains present but unused. Lock-loss behaviour is identical in both builds.

## Test plan
Use defaults (NUM_DOMAINS=4, SYNC_STAGES=2, LOCK_FILTER=8, STAGE_DELAY=16) unless stated.
- Clean power-up: assert reset_in, deassert it, hold pll_locked_in=1 → rst_n_out goes 0001, 0011, 0111, 1111 at 16, 32, 48, 64 cycles after entering RELEASE; seq_done=1 with 1111; state_out=3.
- Lock glitch during filtering: drop lock for 1 cycle after 5 synced-high cycles → filter restarts; RELEASE is entered 8 synced-high cycles after lock returns.
- Lock loss in RUN: drop pll_locked_in → within 3 cycles rst_n_out=0000, seq_done=0, lock_lost_cnt=1, state_out=4; FAULT holds 16 cycles, then the full release sequence repeats.
- Lock loss mid-RELEASE (rst_n_out=0011) → same cycle-accurate FAULT behaviour as in RUN; the resequence starts from bit 0.
- sw_rst_req pulse in RUN: with the macro defined, FAULT is entered and lock_lost_cnt is unchanged; without the macro, there is no change; a pulse in WAIT_LOCK is ignored in both builds. Simultaneous lock loss and sw_rst_req → count increments by 1.
- Saturation and reset: force 300 lock-loss faults → lock_lost_cnt=255. Then assert reset_in mid-RELEASE → all outputs return to reset values immediately.
